// File: rtl/wb_ic_pkg.sv
// Shared definitions for the Wishbone parameterised interconnect.
//   ic_state_e : bus-transaction FSM states
//   SEL_W      : width of the slave-select field in the master address
//   TMO_W      : width of the saturating slave-ack timeout counter
package wb_ic_pkg;

    localparam int SEL_W = 8;
    localparam int TMO_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        RESP  = 2'd2,
        DRAIN = 2'd3
    } ic_state_e;

endpackage

// File: rtl/wb_ic_decode.sv
// Address decoder for the interconnect.
//   adr       in  32     master address
//   index     out SEL_W  slave index taken from adr[SEL_LSB +: SEL_W]
//   mapped    out 1      index addresses an existing slave port
//   slave_adr out 32     address as seen by the slave (select field zeroed)
module wb_ic_decode
    import wb_ic_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter int SEL_LSB    = 24
) (
    input  logic [31:0]      adr,
    output logic [SEL_W-1:0] index,
    output logic             mapped,
    output logic [31:0]      slave_adr
);

    localparam logic [31:0] SEL_MASK = ~(32'h0000_00FF << SEL_LSB);

    assign index     = adr[SEL_LSB +: SEL_W];
    assign mapped    = ({{(32-SEL_W){1'b0}}, index} < 32'(NUM_SLAVES));
    assign slave_adr = adr & SEL_MASK;

endmodule

// File: rtl/wb_param_interconnect.sv
// Single-master, NUM_SLAVES-slave Wishbone interconnect with bus-error
// generation for unmapped addresses, a slave-ack timeout and a masked
// interrupt aggregator.
//   clk, rst_n                       clock / async active-low reset
//   i_m_*                            master request (we, stb, cyc, sel, adr, dat)
//   o_m_dat, o_m_ack, o_m_err        master response (registered)
//   o_m_int                          any unmasked interrupt pending
//   o_s_we/stb/cyc/sel/adr/dat       per-slave request, slice k = slave k
//   i_s_dat, i_s_ack, i_s_int        per-slave response / interrupt level
//   i_int_mask                       1 = slave interrupt enabled
//   o_int_vec                        registered masked interrupts
module wb_param_interconnect
    import wb_ic_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter int SEL_LSB    = 24,
    parameter int TIMEOUT    = 255,
    parameter int INT_WIDTH  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_m_we,
    input  logic                     i_m_stb,
    input  logic                     i_m_cyc,
    input  logic [3:0]               i_m_sel,
    input  logic [31:0]              i_m_adr,
    input  logic [31:0]              i_m_dat,
    output logic [31:0]              o_m_dat,
    output logic                     o_m_ack,
    output logic                     o_m_err,
    output logic                     o_m_int,
    output logic [NUM_SLAVES-1:0]    o_s_we,
    output logic [NUM_SLAVES-1:0]    o_s_stb,
    output logic [NUM_SLAVES-1:0]    o_s_cyc,
    output logic [4*NUM_SLAVES-1:0]  o_s_sel,
    output logic [32*NUM_SLAVES-1:0] o_s_adr,
    output logic [32*NUM_SLAVES-1:0] o_s_dat,
    input  logic [32*NUM_SLAVES-1:0] i_s_dat,
    input  logic [NUM_SLAVES-1:0]    i_s_ack,
    input  logic [NUM_SLAVES-1:0]    i_s_int,
    input  logic [NUM_SLAVES-1:0]    i_int_mask,
    output logic [INT_WIDTH-1:0]     o_int_vec
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    ic_state_e               state_r;
    ic_state_e               state_next_s;
    logic [SEL_W-1:0]        dec_idx_s;
    logic                    dec_mapped_s;
    logic [31:0]             dec_adr_s;
    logic [TMO_W-1:0]        tmo_cnt_r;
    logic                    ack_hit_s;
    logic                    tmo_hit_s;
    logic [31:0]             rd_mux_s;
    logic                    go_busy_s;
    logic                    leave_busy_s;
    logic                    resp_load_s;
    logic                    resp_err_d_s;
    logic [31:0]             resp_dat_d_s;
    logic                    resp_err_r;
    logic [31:0]             m_dat_r;
    logic                    m_ack_r;
    logic                    m_err_r;
    logic [NUM_SLAVES-1:0]   s_we_r;
    logic [NUM_SLAVES-1:0]   s_stb_r;
    logic [NUM_SLAVES-1:0]   s_cyc_r;
    logic [4*NUM_SLAVES-1:0] s_sel_r;
    logic [32*NUM_SLAVES-1:0] s_adr_r;
    logic [32*NUM_SLAVES-1:0] s_dat_r;
    logic [INT_WIDTH-1:0]    int_vec_r;

    wb_ic_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .SEL_LSB    (SEL_LSB)
    ) u_decode (
        .adr       (i_m_adr),
        .index     (dec_idx_s),
        .mapped    (dec_mapped_s),
        .slave_adr (dec_adr_s)
    );

    // Strobes are one-hot on the selected slave, so they double as the ack/data select.
    assign ack_hit_s = |(i_s_ack & s_stb_r);
    assign tmo_hit_s = (tmo_cnt_r >= TMO_LAST);

    // Read-data mux keyed by the active slave strobe
    always_comb begin
        rd_mux_s = 32'h0000_0000;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            rd_mux_s = s_stb_r[i] ? i_s_dat[32*i +: 32] : rd_mux_s;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; master abort wins over ack, ack wins over timeout
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (i_m_cyc && i_m_stb) begin
                    state_next_s = dec_mapped_s ? BUSY : RESP;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                if (!i_m_cyc) begin
                    state_next_s = IDLE;
                end else if (ack_hit_s || tmo_hit_s) begin
                    state_next_s = RESP;
                end else begin
                    state_next_s = BUSY;
                end
            end
            RESP: begin
                state_next_s = DRAIN;
            end
            DRAIN: begin
                if (!i_m_stb) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // FSM output decode: transition strobes and the response to capture
    always_comb begin
        go_busy_s    = (state_r == IDLE) && (state_next_s == BUSY);
        leave_busy_s = (state_r == BUSY) && (state_next_s != BUSY);
        resp_load_s  = (state_next_s == RESP);
        resp_err_d_s = !((state_r == BUSY) && ack_hit_s);
        resp_dat_d_s = resp_err_d_s ? 32'h0000_0000 : rd_mux_s;
    end

    // Saturating timeout counter, restarted on every entry to BUSY
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end else if (go_busy_s) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end else if ((state_r == BUSY) && (tmo_cnt_r != {TMO_W{1'b1}})) begin
            tmo_cnt_r <= tmo_cnt_r + {{(TMO_W-1){1'b0}}, 1'b1};
        end
    end

    // Slave-side request registers: loaded for slave k on BUSY entry, cleared on exit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_we_r  <= {NUM_SLAVES{1'b0}};
            s_stb_r <= {NUM_SLAVES{1'b0}};
            s_cyc_r <= {NUM_SLAVES{1'b0}};
            s_sel_r <= {(4*NUM_SLAVES){1'b0}};
            s_adr_r <= {(32*NUM_SLAVES){1'b0}};
            s_dat_r <= {(32*NUM_SLAVES){1'b0}};
        end else if (go_busy_s) begin
            for (int i = 0; i < NUM_SLAVES; i++) begin
                if (SEL_W'(i) == dec_idx_s) begin
                    s_we_r[i]           <= i_m_we;
                    s_stb_r[i]          <= 1'b1;
                    s_cyc_r[i]          <= 1'b1;
                    s_sel_r[4*i +: 4]   <= i_m_sel;
                    s_adr_r[32*i +: 32] <= dec_adr_s;
                    s_dat_r[32*i +: 32] <= i_m_dat;
                end else begin
                    s_we_r[i]           <= 1'b0;
                    s_stb_r[i]          <= 1'b0;
                    s_cyc_r[i]          <= 1'b0;
                    s_sel_r[4*i +: 4]   <= 4'h0;
                    s_adr_r[32*i +: 32] <= 32'h0000_0000;
                    s_dat_r[32*i +: 32] <= 32'h0000_0000;
                end
            end
        end else if (leave_busy_s) begin
            s_we_r  <= {NUM_SLAVES{1'b0}};
            s_stb_r <= {NUM_SLAVES{1'b0}};
            s_cyc_r <= {NUM_SLAVES{1'b0}};
            s_sel_r <= {(4*NUM_SLAVES){1'b0}};
            s_adr_r <= {(32*NUM_SLAVES){1'b0}};
            s_dat_r <= {(32*NUM_SLAVES){1'b0}};
        end
    end

    // Master response: outcome captured entering RESP, pulsed the cycle after
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_err_r <= 1'b0;
            m_dat_r    <= 32'h0000_0000;
            m_ack_r    <= 1'b0;
            m_err_r    <= 1'b0;
        end else begin
            if (resp_load_s) begin
                resp_err_r <= resp_err_d_s;
                m_dat_r    <= resp_dat_d_s;
            end
            m_ack_r <= (state_r == RESP) && !resp_err_r;
            m_err_r <= (state_r == RESP) && resp_err_r;
        end
    end

    // Masked interrupt vector, sampled every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_vec_r <= {INT_WIDTH{1'b0}};
        end else begin
            int_vec_r <= INT_WIDTH'(i_s_int & i_int_mask);
        end
    end

    assign o_m_dat   = m_dat_r;
    assign o_m_ack   = m_ack_r;
    assign o_m_err   = m_err_r;
    assign o_m_int   = (int_vec_r != {INT_WIDTH{1'b0}});
    assign o_s_we    = s_we_r;
    assign o_s_stb   = s_stb_r;
    assign o_s_cyc   = s_cyc_r;
    assign o_s_sel   = s_sel_r;
    assign o_s_adr   = s_adr_r;
    assign o_s_dat   = s_dat_r;
    assign o_int_vec = int_vec_r;

endmodule

// File: tb/tb_wb_param_interconnect.sv
// Self-checking bench for wb_param_interconnect (4 slaves, TIMEOUT = 8).
// Each transaction writes its expected per-cycle outcome into schedule
// tables derived from the bus timing rules; a negedge process compares the
// DUT against those tables every cycle, and a few literal pins anchor them.
module tb_wb_param_interconnect;

    localparam int NS    = 4;
    localparam int TMO   = 8;
    localparam int IW    = 32;
    localparam int DEPTH = 1024;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              i_m_we, i_m_stb, i_m_cyc;
    logic [3:0]        i_m_sel;
    logic [31:0]       i_m_adr, i_m_dat;
    logic [31:0]       o_m_dat;
    logic              o_m_ack, o_m_err, o_m_int;
    logic [NS-1:0]     o_s_we, o_s_stb, o_s_cyc;
    logic [4*NS-1:0]   o_s_sel;
    logic [32*NS-1:0]  o_s_adr, o_s_dat;
    logic [32*NS-1:0]  i_s_dat;
    logic [NS-1:0]     i_s_ack, i_s_int, i_int_mask;
    logic [IW-1:0]     o_int_vec;

    wb_param_interconnect #(
        .NUM_SLAVES (NS),
        .SEL_LSB    (24),
        .TIMEOUT    (TMO),
        .INT_WIDTH  (IW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_m_we     (i_m_we),
        .i_m_stb    (i_m_stb),
        .i_m_cyc    (i_m_cyc),
        .i_m_sel    (i_m_sel),
        .i_m_adr    (i_m_adr),
        .i_m_dat    (i_m_dat),
        .o_m_dat    (o_m_dat),
        .o_m_ack    (o_m_ack),
        .o_m_err    (o_m_err),
        .o_m_int    (o_m_int),
        .o_s_we     (o_s_we),
        .o_s_stb    (o_s_stb),
        .o_s_cyc    (o_s_cyc),
        .o_s_sel    (o_s_sel),
        .o_s_adr    (o_s_adr),
        .o_s_dat    (o_s_dat),
        .i_s_dat    (i_s_dat),
        .i_s_ack    (i_s_ack),
        .i_s_int    (i_s_int),
        .i_int_mask (i_int_mask),
        .o_int_vec  (o_int_vec)
    );

    always #5 clk = ~clk;

    int cyc_n = 0;
    int n_cmp = 0;
    int n_bad = 0;

    // Expected per-cycle behaviour (index = cycle number, 0 = idle)
    bit [NS-1:0] exp_stb  [DEPTH];
    int          exp_k    [DEPTH];
    bit [31:0]   exp_adr  [DEPTH];
    bit [31:0]   exp_wdat [DEPTH];
    bit          exp_we   [DEPTH];
    bit [3:0]    exp_sel  [DEPTH];
    bit          exp_ack  [DEPTH];
    bit          exp_err  [DEPTH];
    bit [31:0]   exp_dat  [DEPTH];
    logic [31:0] sdat     [NS];
    logic [IW-1:0] int_model;
    int p0;

    // Cycle counter: value during cycle N is the number of rising edges so far
    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Interrupt reference: masked levels sampled each clock, cleared by reset
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) int_model <= '0;
        else        int_model <= IW'(i_s_int & i_int_mask);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got 0x%08h expected 0x%08h", name, cyc_n, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg(input int target);
        while (cyc_n < target) @(negedge clk);
    endtask

    // Per-cycle comparison against the schedule tables
    always @(negedge clk) begin
        int c;
        int k;
        c = cyc_n;
        if (c < DEPTH) begin
            chk("s_stb",   32'(o_s_stb), 32'(exp_stb[c]));
            chk("s_cyc",   32'(o_s_cyc), 32'(exp_stb[c]));
            chk("m_ack",   32'(o_m_ack), 32'(exp_ack[c]));
            chk("m_err",   32'(o_m_err), 32'(exp_err[c]));
            chk("int_vec", o_int_vec, int_model);
            chk("m_int",   32'(o_m_int), 32'(int_model != '0));
            if (exp_ack[c] || exp_err[c]) chk("m_dat", o_m_dat, exp_dat[c]);
            if (exp_stb[c] != '0) begin
                k = exp_k[c];
                chk("s_adr", o_s_adr[32*k +: 32], exp_adr[c]);
                chk("s_dat", o_s_dat[32*k +: 32], exp_wdat[c]);
                chk("s_we",  32'(o_s_we[k]), 32'(exp_we[c]));
                chk("s_sel", 32'(o_s_sel[4*k +: 4]), 32'(exp_sel[c]));
            end
        end
    end

    // One master transaction. d = slave ack delay in strobe cycles (-1 = never),
    // abort_at >= 0 drops i_m_cyc that many cycles after the strobe first shows.
    task automatic txn(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                       input logic [3:0] sel, input int d, input int abort_at);
        int  p, k, nb, resp, last;
        bit  is_err;
        p = cyc_n;
        k = int'(adr[31:24]);
        if (k >= NS) begin
            nb = 0; resp = p + 2; is_err = 1'b1;
        end else if (abort_at >= 0) begin
            nb = abort_at + 1; resp = -1; is_err = 1'b0;
        end else if (d >= 0 && d < TMO) begin
            nb = d + 1; resp = p + 3 + d; is_err = 1'b0;
        end else begin
            nb = TMO; resp = p + 2 + TMO; is_err = 1'b1;
        end
        for (int j = 1; j <= nb; j++) begin
            exp_stb[p+j]  = {{(NS-1){1'b0}}, 1'b1} << k;
            exp_k[p+j]    = k;
            exp_adr[p+j]  = {8'h00, adr[23:0]};
            exp_wdat[p+j] = wdat;
            exp_we[p+j]   = we;
            exp_sel[p+j]  = sel;
        end
        if (resp >= 0) begin
            exp_ack[resp] = !is_err;
            exp_err[resp] = is_err;
            if (is_err) exp_dat[resp] = 32'h0000_0000;
            else        exp_dat[resp] = sdat[k];
        end
        i_m_adr = adr; i_m_we = we; i_m_dat = wdat; i_m_sel = sel;
        i_m_cyc = 1'b1; i_m_stb = 1'b1;
        last = (resp >= 0) ? resp + 1 : p + 1 + abort_at;
        while (cyc_n < last) begin
            next_cycle();
            i_s_ack = '0;
            if (k < NS && abort_at < 0 && d >= 0 && cyc_n == p + 1 + d) i_s_ack[k] = 1'b1;
            // an ack from a slave that was not selected must be ignored
            if (k < NS && d != 0 && cyc_n == p + 1) i_s_ack[(k + 1) % NS] = 1'b1;
        end
        i_m_cyc = 1'b0; i_m_stb = 1'b0; i_s_ack = '0;
        next_cycle();
    endtask

    initial begin
        i_m_we = 1'b0; i_m_stb = 1'b0; i_m_cyc = 1'b0;
        i_m_sel = 4'h0; i_m_adr = 32'h0; i_m_dat = 32'h0;
        i_s_ack = '0; i_s_int = 4'b0110; i_int_mask = 4'b1111;
        for (int i = 0; i < NS; i++) sdat[i] = 32'hA5A5_0000 + 32'(i);
        sdat[2] = 32'hDEAD_BEEF;
        for (int i = 0; i < NS; i++) i_s_dat[32*i +: 32] = sdat[i];

        #1 rst_n = 1'b0;
        #3;
        chk("rst_m_ack", 32'(o_m_ack), 32'h0);
        chk("rst_m_err", 32'(o_m_err), 32'h0);
        chk("rst_m_dat", o_m_dat, 32'h0);
        chk("rst_int_vec", o_int_vec, 32'h0);
        chk("rst_s_stb", 32'(o_s_stb), 32'h0);
        chk("rst_s_adr", 32'(o_s_adr != '0), 32'h0);
        repeat (3) next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // write to slave 1, ack two cycles after the strobe appears
        p0 = cyc_n;
        fork
            txn(32'h0100_0010, 1'b1, 32'h1234_5678, 4'hF, 2, -1);
            begin
                at_neg(p0 + 1);
                chk("w_stb_lit", 32'(o_s_stb), 32'h2);
                chk("w_adr_lit", o_s_adr[63:32], 32'h0000_0010);
                at_neg(p0 + 5);
                chk("w_ack_lit", 32'(o_m_ack), 32'h1);
                at_neg(p0 + 6);
                chk("w_ack_off", 32'(o_m_ack), 32'h0);
            end
        join

        // read from slave 2
        p0 = cyc_n;
        fork
            txn(32'h0200_0004, 1'b0, 32'h0, 4'hF, 1, -1);
            begin
                at_neg(p0 + 4);
                chk("r_ack_lit", 32'(o_m_ack), 32'h1);
                chk("r_dat_lit", o_m_dat, 32'hDEAD_BEEF);
            end
        join

        // unmapped select 0x05
        p0 = cyc_n;
        fork
            txn(32'h0500_0000, 1'b0, 32'h0, 4'hF, 0, -1);
            begin
                at_neg(p0 + 1);
                chk("u_stb_lit", 32'(o_s_stb), 32'h0);
                at_neg(p0 + 2);
                chk("u_err_lit", 32'(o_m_err), 32'h1);
                chk("u_dat_lit", o_m_dat, 32'h0);
            end
        join

        // first unmapped index, last mapped index with minimum latency
        txn(32'h0400_0020, 1'b1, 32'h5555_AAAA, 4'h1, 0, -1);
        p0 = cyc_n;
        fork
            txn(32'h03AB_CDEF, 1'b0, 32'h0, 4'hC, 0, -1);
            begin
                at_neg(p0 + 3);
                chk("min_lat_lit", 32'(o_m_ack), 32'h1);
            end
        join

        // slave 0 never acks: timeout after TMO busy cycles
        p0 = cyc_n;
        fork
            txn(32'h0000_0100, 1'b1, 32'hCAFE_0001, 4'h3, -1, -1);
            begin
                at_neg(p0 + 8);
                chk("to_stb_on", 32'(o_s_stb), 32'h1);
                at_neg(p0 + 9);
                chk("to_stb_off", 32'(o_s_stb), 32'h0);
                at_neg(p0 + 10);
                chk("to_err_lit", 32'(o_m_err), 32'h1);
            end
        join

        // ack on the last cycle before timeout still succeeds
        txn(32'h0200_0300, 1'b0, 32'h0, 4'hF, TMO - 1, -1);
        // master abort in BUSY
        txn(32'h01FF_FFFC, 1'b1, 32'h7777_8888, 4'h6, -1, 2);
        txn(32'h0100_0008, 1'b0, 32'h0, 4'hF, 3, -1);

        // reset pulsed mid-transfer
        p0 = cyc_n;
        exp_stb[p0+1]  = 4'b0100;
        exp_k[p0+1]    = 2;
        exp_adr[p0+1]  = 32'h0000_0040;
        exp_wdat[p0+1] = 32'h0BAD_F00D;
        exp_we[p0+1]   = 1'b1;
        exp_sel[p0+1]  = 4'h3;
        i_m_adr = 32'h0200_0040; i_m_we = 1'b1; i_m_dat = 32'h0BAD_F00D; i_m_sel = 4'h3;
        i_m_cyc = 1'b1; i_m_stb = 1'b1;
        next_cycle();
        @(negedge clk);
        #2;
        rst_n = 1'b0; i_m_cyc = 1'b0; i_m_stb = 1'b0;
        #1;
        chk("mid_rst_stb", 32'(o_s_stb), 32'h0);
        chk("mid_rst_cyc", 32'(o_s_cyc), 32'h0);
        chk("mid_rst_ack", 32'(o_m_ack), 32'h0);
        chk("mid_rst_err", 32'(o_m_err), 32'h0);
        chk("mid_rst_dat", o_m_dat, 32'h0);
        chk("mid_rst_int", o_int_vec, 32'h0);
        chk("mid_rst_mint", 32'(o_m_int), 32'h0);
        chk("mid_rst_sadr", 32'(o_s_adr != '0), 32'h0);
        chk("mid_rst_sdat", 32'(o_s_dat != '0), 32'h0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        next_cycle();
        txn(32'h0200_0044, 1'b0, 32'h0, 4'hF, 1, -1);

        // interrupt masking
        i_s_int = 4'b1010; i_int_mask = 4'b0010;
        next_cycle();
        chk("int_vec_lit", o_int_vec, 32'h0000_0002);
        chk("m_int_lit", 32'(o_m_int), 32'h1);
        i_int_mask = 4'b0000;
        next_cycle();
        chk("int_mask0_lit", o_int_vec, 32'h0);
        chk("m_int0_lit", 32'(o_m_int), 32'h0);
        i_s_int = 4'b1111; i_int_mask = 4'b1001;
        repeat (2) next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
